// File: rtl/snake_game_ctrl_if.sv
// Snake game controller bus.
// Groups the game control inputs (start, tick, direction request), the VGA
// pixel position and the game-state outputs (cell kind under the pixel,
// apple position, score, game-over flag).
//   master: drives controls and pixel position, observes game state
//   slave : the snake_game_ctrl core
interface snake_game_ctrl_if;
  logic       start;
  logic       tick;
  logic       dir_valid;
  logic [1:0] dir_in;
  logic [9:0] vga_xpos;
  logic [9:0] vga_ypos;
  logic [1:0] cube_kind;
  logic [5:0] apple_x;
  logic [5:0] apple_y;
  logic [7:0] score;
  logic       game_over;

  modport master (
    output start, tick, dir_valid, dir_in, vga_xpos, vga_ypos,
    input  cube_kind, apple_x, apple_y, score, game_over
  );

  modport slave (
    input  start, tick, dir_valid, dir_in, vga_xpos, vga_ypos,
    output cube_kind, apple_x, apple_y, score, game_over
  );
endinterface

// File: rtl/snake_game_ctrl.sv
// Snake game controller on a 40x30 grid of 16x16 px cells.
// Ports:
//   clk   - system clock, all state on rising edge
//   rst_n - asynchronous active-low reset
//   bus   - snake_game_ctrl_if.slave:
//           start/tick/dir_valid/dir_in  game controls
//           vga_xpos/vga_ypos            current pixel
//           cube_kind                    cell kind under pixel, 1 clk later
//                                        (00 none, 01 head, 10 body, 11 wall)
//           apple_x/apple_y              apple cell
//           score                        apples eaten this game
//           game_over                    high while the snake is dead
// One move per accepted tick: RUN -> STEP (next head) -> UPDATE (collision,
// shift, grow) -> RUN, or -> PLACE (pick a new apple) -> RUN, or -> DEAD.
module snake_game_ctrl #(
  parameter int MAX_LEN  = 16,
  parameter int INIT_LEN = 3
) (
  input logic             clk,
  input logic             rst_n,
  snake_game_ctrl_if.slave bus
);

  localparam int LW = $clog2(MAX_LEN + 1);

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [2:0] {IDLE, RUN, STEP, UPDATE, PLACE, DEAD} state_t;

  // Initial snake: head at (20,15), body trailing to the left.
  function automatic logic [11:0] init_seg(input int idx);
    if (idx < 3) return {6'(20 - idx), 6'd15};
    else         return 12'd0;
  endfunction

  // Up/down and left/right share bit 1 and differ in bit 0.
  function automatic logic is_reverse(input logic [1:0] a, input logic [1:0] b);
    return (a[1] == b[1]) && (a[0] != b[0]);
  endfunction

  state_t      state_reg;
  logic [11:0] seg_reg [MAX_LEN];
  logic [LW-1:0] len_reg;
  logic [1:0]  dir_cmt_reg;
  logic [1:0]  dir_pend_reg;
  logic [11:0] nh_reg;
  logic [15:0] lfsr_reg;
  logic [5:0]  apple_x_reg;
  logic [5:0]  apple_y_reg;
  logic [7:0]  score_reg;
  logic        game_over_reg;
  logic [1:0]  cube_kind_reg;

  // ---------------------------------------------------------------- LFSR
  logic lfsr_fb;
  assign lfsr_fb = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_reg <= LFSR_SEED;
    else        lfsr_reg <= {lfsr_reg[14:0], lfsr_fb};
  end

  logic [5:0] cand_x;
  logic [5:0] cand_y;
  logic       cand_ok;
  assign cand_x  = lfsr_reg[5:0];
  assign cand_y  = {1'b0, lfsr_reg[12:8]};
  assign cand_ok = (cand_x >= 6'd1) && (cand_x <= 6'd38) &&
                   (cand_y >= 6'd1) && (cand_y <= 6'd28);

  // ------------------------------------------------------ next head / hits
  logic [5:0]  head_x;
  logic [5:0]  head_y;
  logic [11:0] head_next;
  assign head_x = seg_reg[0][11:6];
  assign head_y = seg_reg[0][5:0];

  always_comb begin
    head_next = seg_reg[0];
    case (dir_cmt_reg)
      DIR_UP:    head_next = {head_x, head_y - 6'd1};
      DIR_DOWN:  head_next = {head_x, head_y + 6'd1};
      DIR_LEFT:  head_next = {head_x - 6'd1, head_y};
      default:   head_next = {head_x + 6'd1, head_y};
    endcase
  end

  logic [5:0] nh_x;
  logic [5:0] nh_y;
  logic       wall_hit;
  logic       eat_hit;
  assign nh_x     = nh_reg[11:6];
  assign nh_y     = nh_reg[5:0];
  assign wall_hit = (nh_x == 6'd0) || (nh_x == 6'd39) || (nh_y == 6'd0) || (nh_y == 6'd29);
  assign eat_hit  = (nh_reg == {apple_x_reg, apple_y_reg});

  logic [5:0] pix_x;
  logic [5:0] pix_y;
  assign pix_x = bus.vga_xpos[9:4];
  assign pix_y = bus.vga_ypos[9:4];

  // body_hit_vec: the tail cell (index len-1) vacates during the move, so it
  // is excluded from self-collision.
  logic [MAX_LEN-1:0] body_hit_vec;
  logic [MAX_LEN-1:0] pix_hit_vec;
  generate
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_seg_cmp
      assign body_hit_vec[gi] = (LW'(gi + 1) < len_reg) && (seg_reg[gi] == nh_reg);
      assign pix_hit_vec[gi]  = (LW'(gi) < len_reg) && (seg_reg[gi] == {pix_x, pix_y});
    end
  endgenerate

  // Pending direction is checked against the direction that will be committed
  // at the coming STEP, so two quick requests can never produce a reversal.
  logic [1:0] dir_ref;
  assign dir_ref = (state_reg == RUN && bus.tick) ? dir_pend_reg : dir_cmt_reg;

  // ------------------------------------------------------------------ FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      for (int i = 0; i < MAX_LEN; i++) seg_reg[i] <= init_seg(i);
      len_reg       <= LW'(INIT_LEN);
      dir_cmt_reg   <= DIR_RIGHT;
      dir_pend_reg  <= DIR_RIGHT;
      nh_reg        <= 12'd0;
      apple_x_reg   <= 6'd30;
      apple_y_reg   <= 6'd15;
      score_reg     <= 8'd0;
      game_over_reg <= 1'b0;
    end else begin
      if (bus.dir_valid && !is_reverse(bus.dir_in, dir_ref))
        dir_pend_reg <= bus.dir_in;

      case (state_reg)
        IDLE: begin
          if (bus.start) state_reg <= RUN;
        end
        RUN: begin
          if (bus.tick) begin
            dir_cmt_reg <= dir_pend_reg;
            state_reg   <= STEP;
          end
        end
        STEP: begin
          nh_reg    <= head_next;
          state_reg <= UPDATE;
        end
        UPDATE: begin
          if (wall_hit || (|body_hit_vec)) begin
            game_over_reg <= 1'b1;
            state_reg     <= DEAD;
          end else begin
            for (int i = 1; i < MAX_LEN; i++) seg_reg[i] <= seg_reg[i-1];
            seg_reg[0] <= nh_reg;
            if (eat_hit) begin
              if (len_reg != LW'(MAX_LEN)) len_reg <= len_reg + LW'(1);
              if (score_reg != 8'hFF)      score_reg <= score_reg + 8'd1;
              state_reg <= PLACE;
            end else begin
              state_reg <= RUN;
            end
          end
        end
        PLACE: begin
          // Apple may land on the body; only the wall ring is excluded.
          if (cand_ok) begin
            apple_x_reg <= cand_x;
            apple_y_reg <= cand_y;
            state_reg   <= RUN;
          end
        end
        DEAD: begin
          if (bus.start) begin
            for (int i = 0; i < MAX_LEN; i++) seg_reg[i] <= init_seg(i);
            len_reg       <= LW'(INIT_LEN);
            dir_cmt_reg   <= DIR_RIGHT;
            dir_pend_reg  <= DIR_RIGHT;
            apple_x_reg   <= 6'd30;
            apple_y_reg   <= 6'd15;
            score_reg     <= 8'd0;
            game_over_reg <= 1'b0;
            state_reg     <= RUN;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // ------------------------------------------------------------- display
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cube_kind_reg <= 2'b00;
    end else if (bus.vga_xpos >= 10'd640 || bus.vga_ypos >= 10'd480) begin
      cube_kind_reg <= 2'b00;
    end else if (pix_x == 6'd0 || pix_x == 6'd39 || pix_y == 6'd0 || pix_y == 6'd29) begin
      cube_kind_reg <= 2'b11;
    end else if (pix_hit_vec[0]) begin
      cube_kind_reg <= 2'b01;
    end else if (|pix_hit_vec[MAX_LEN-1:1]) begin
      cube_kind_reg <= 2'b10;
    end else begin
      cube_kind_reg <= 2'b00;
    end
  end

  assign bus.cube_kind = cube_kind_reg;
  assign bus.apple_x   = apple_x_reg;
  assign bus.apple_y   = apple_y_reg;
  assign bus.score     = score_reg;
  assign bus.game_over = game_over_reg;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Testbench for snake_game_ctrl: pixel probes go through a scoreboard queue
// (expected cell kind pushed when the pixel is driven, popped one clock later
// when cube_kind is registered); game-state outputs are checked directly.
module tb_snake_game_ctrl;

  logic clk;
  logic rst_n;

  snake_game_ctrl_if bus ();

  snake_game_ctrl #(.MAX_LEN(16), .INIT_LEN(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [1:0] kind;
  } probe_t;

  probe_t exp_q[$];
  logic   probe_vld;
  int     n_checks;
  int     n_pass;

  localparam logic [1:0] K_NONE = 2'b00;
  localparam logic [1:0] K_HEAD = 2'b01;
  localparam logic [1:0] K_BODY = 2'b10;
  localparam logic [1:0] K_WALL = 2'b11;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) begin
      n_pass++;
      $display("check %-14s got %0d expected %0d ok", tag, obs, exp_v);
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Scoreboard consumer: cube_kind for a probed pixel is valid just after the
  // next rising edge.
  always @(posedge clk) begin
    if (probe_vld) begin
      #1;
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        probe_t e;
        e = exp_q.pop_front();
        chk(e.tag, 32'(bus.cube_kind), 32'(e.kind));
      end
    end
  end

  task automatic probe_px(input string tag, input int px, input int py, input logic [1:0] k);
    @(negedge clk);
    bus.vga_xpos = 10'(px);
    bus.vga_ypos = 10'(py);
    exp_q.push_back('{tag, k});
    probe_vld = 1'b1;
    @(negedge clk);
    probe_vld = 1'b0;
  endtask

  task automatic probe_cell(input string tag, input int cx, input int cy, input logic [1:0] k);
    probe_px(tag, cx * 16 + 8, cy * 16 + 8, k);
  endtask

  task automatic pulse_start();
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
  endtask

  task automatic set_dir(input logic [1:0] d);
    @(negedge clk); bus.dir_valid = 1'b1; bus.dir_in = d;
    @(negedge clk); bus.dir_valid = 1'b0;
  endtask

  // One tick, then enough cycles for STEP and UPDATE to complete.
  task automatic do_tick();
    @(negedge clk); bus.tick = 1'b1;
    @(negedge clk); bus.tick = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks      = 0;
    n_pass        = 0;
    probe_vld     = 1'b0;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.tick      = 1'b0;
    bus.dir_valid = 1'b0;
    bus.dir_in    = 2'b00;
    bus.vga_xpos  = 10'd0;
    bus.vga_ypos  = 10'd0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_cube", 32'(bus.cube_kind), 32'd0);
    chk("rst_over", 32'(bus.game_over), 32'd0);
    chk("rst_score", 32'(bus.score), 32'd0);
    chk("rst_apple_x", 32'(bus.apple_x), 32'd30);
    chk("rst_apple_y", 32'(bus.apple_y), 32'd15);
    rst_n = 1'b1;

    // Initial snake and display decoding
    probe_px("px_320_240", 320, 240, K_HEAD);
    probe_cell("init_seg1", 19, 15, K_BODY);
    probe_cell("init_seg2", 18, 15, K_BODY);
    probe_cell("init_beyond", 17, 15, K_NONE);
    probe_px("px_0_0", 0, 0, K_WALL);
    probe_px("px_700_10", 700, 10, K_NONE);
    probe_cell("wall_col39", 39, 10, K_WALL);
    probe_cell("wall_row29", 10, 29, K_WALL);
    probe_px("px_100_480", 100, 480, K_NONE);

    // Tick in IDLE is ignored
    do_tick();
    probe_cell("idle_tick", 20, 15, K_HEAD);

    // Start, three moves right
    pulse_start();
    repeat (3) do_tick();
    probe_cell("mv3_head", 23, 15, K_HEAD);
    probe_cell("mv3_seg1", 22, 15, K_BODY);
    probe_cell("mv3_seg2", 21, 15, K_BODY);
    probe_cell("mv3_old", 20, 15, K_NONE);
    chk("mv3_score", 32'(bus.score), 32'd0);
    chk("mv3_over", 32'(bus.game_over), 32'd0);

    // Tick on two consecutive cycles: one move
    @(negedge clk); bus.tick = 1'b1;
    @(negedge clk);
    @(negedge clk); bus.tick = 1'b0;
    repeat (3) @(negedge clk);
    probe_cell("dbl_head", 24, 15, K_HEAD);
    probe_cell("dbl_ahead", 25, 15, K_NONE);

    // Start while running is ignored
    pulse_start();
    probe_cell("run_start", 24, 15, K_HEAD);

    // Reverse request ignored
    set_dir(2'b10);
    do_tick();
    probe_cell("rev_head", 25, 15, K_HEAD);

    // Moves 6..9 then the 10th eats the apple at (30,15)
    repeat (4) do_tick();
    chk("pre_eat_score", 32'(bus.score), 32'd0);
    chk("pre_eat_ax", 32'(bus.apple_x), 32'd30);
    do_tick();
    chk("eat_score", 32'(bus.score), 32'd1);
    probe_cell("eat_head", 30, 15, K_HEAD);
    probe_cell("eat_body3", 27, 15, K_BODY);
    probe_cell("eat_len4", 26, 15, K_NONE);
    repeat (300) @(negedge clk);
    chk("apple_x_rng", 32'(bus.apple_x >= 6'd1 && bus.apple_x <= 6'd38), 32'd1);
    chk("apple_y_rng", 32'(bus.apple_y >= 6'd1 && bus.apple_y <= 6'd28), 32'd1);
    do_tick();
    probe_cell("place_exit", 31, 15, K_HEAD);

    // Reset asserted during UPDATE: move abandoned
    @(negedge clk); bus.tick = 1'b1;
    @(negedge clk); bus.tick = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk); rst_n = 1'b1;
    probe_cell("mid_rst_head", 20, 15, K_HEAD);
    probe_cell("mid_rst_old", 31, 15, K_NONE);
    chk("mid_rst_score", 32'(bus.score), 32'd0);
    chk("mid_rst_ax", 32'(bus.apple_x), 32'd30);

    // Up is accepted
    pulse_start();
    set_dir(2'b00);
    do_tick();
    probe_cell("up_head", 20, 14, K_HEAD);
    probe_cell("up_seg1", 20, 15, K_BODY);
    probe_cell("up_seg2", 19, 15, K_BODY);

    // Drive right into column 39
    set_dir(2'b11);
    repeat (18) do_tick();
    probe_cell("edge_head", 38, 14, K_HEAD);
    chk("edge_over", 32'(bus.game_over), 32'd0);
    @(negedge clk); bus.tick = 1'b1;
    @(negedge clk); bus.tick = 1'b0;
    @(negedge clk);
    chk("upd_over", 32'(bus.game_over), 32'd0);
    @(negedge clk);
    chk("dead_over", 32'(bus.game_over), 32'd1);
    probe_cell("dead_head", 38, 14, K_HEAD);
    do_tick();
    probe_cell("dead_frozen", 38, 14, K_HEAD);
    probe_cell("dead_body", 37, 14, K_BODY);

    // Restart from DEAD
    pulse_start();
    chk("rs_over", 32'(bus.game_over), 32'd0);
    chk("rs_score", 32'(bus.score), 32'd0);
    probe_cell("rs_head", 20, 15, K_HEAD);
    probe_cell("rs_seg2", 18, 15, K_BODY);
    probe_cell("rs_old", 38, 14, K_NONE);
    do_tick();
    probe_cell("rs_run", 21, 15, K_HEAD);

    @(negedge clk);
    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
